// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA pixel-timing path.
// Defaults describe 640x480@60 with a 25 MHz pixel rate derived from 50 MHz.
package vga_pkg;
  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} vga_phase_t;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_if.sv
// Timing bundle from the VGA controller to the shape/enable stages and the DAC.
interface vga_if
  import vga_pkg::*;
();
  logic               pix_en;
  logic [COORD_W-1:0] Q_X;
  logic [COORD_W-1:0] Q_Y;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  vga_phase_t         h_phase;
  vga_phase_t         v_phase;

  modport master (
    output pix_en, Q_X, Q_Y, hsync, vsync, video_on, line_start, frame_start,
           h_phase, v_phase
  );

  modport slave (
    input  pix_en, Q_X, Q_Y, hsync, vsync, video_on, line_start, frame_start,
           h_phase, v_phase
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: coordinate counter plus phase FSM with registered sync/active.
//
//   state   | meaning
//   PH_ACT  | visible region, count in [0, ACTIVE-1]
//   PH_FP   | front porch after the visible region
//   PH_SYNC | sync pulse, sync_n held low
//   PH_BP   | back porch, ends on the wrap to 0 (also the reset state)
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  output logic [COORD_W-1:0] count,
  output vga_phase_t         phase,
  output logic               sync_n,
  output logic               active,
  output logic               wrap
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [COORD_W-1:0] LAST_ACT  = COORD_W'(ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_FP   = COORD_W'(ACTIVE + FP - 1);
  localparam logic [COORD_W-1:0] LAST_SYNC = COORD_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);

  logic tc;

  assign tc   = (count == LAST);
  assign wrap = adv & tc;

  // Phase transitions look at the count being left, so sync_n/active land
  // on the same edge as the new count they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= LAST;
      phase  <= PH_BP;
      sync_n <= 1'b1;
      active <= 1'b0;
    end else if (adv) begin
      count <= tc ? '0 : count + 1'b1;
      case (phase)
        PH_ACT: begin
          if (count == LAST_ACT) begin
            phase  <= PH_FP;
            active <= 1'b0;
          end
        end
        PH_FP: begin
          if (count == LAST_FP) begin
            phase  <= PH_SYNC;
            sync_n <= 1'b0;
          end
        end
        PH_SYNC: begin
          if (count == LAST_SYNC) begin
            phase  <= PH_BP;
            sync_n <= 1'b1;
          end
        end
        PH_BP: begin
          if (tc) begin
            phase  <= PH_ACT;
            active <= 1'b1;
          end
        end
        default: begin
          phase  <= PH_BP;
          sync_n <= 1'b1;
          active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/vga_controller.sv
// VGA pixel-timing generator: clock divider, H/V axis counters and start pulses.
// Axis totals must stay within 1024 so coordinates fit in COORD_W bits.
module vga_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic  clk,
  input  logic  rst,
  vga_if.master vga
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic               pix_en;
  logic [COORD_W-1:0] h_count, v_count;
  vga_phase_t         h_phase, v_phase;
  logic               h_sync_n, v_sync_n;
  logic               h_active, v_active;
  logic               h_wrap, v_wrap;
  logic               line_start, frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Gated by rst so the strobe drops at once on an asynchronous reset.
  assign pix_en = (div_cnt == DIV_LAST) & ~rst;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (pix_en),
    .count  (h_count),
    .phase  (h_phase),
    .sync_n (h_sync_n),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .adv    (h_wrap),
    .count  (v_count),
    .phase  (v_phase),
    .sync_n (v_sync_n),
    .active (v_active),
    .wrap   (v_wrap)
  );

  // Start pulses are clocked every clk, not per pixel, so they last one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.Q_X         = h_count;
  assign vga.Q_Y         = v_count;
  assign vga.hsync       = h_sync_n;
  assign vga.vsync       = v_sync_n;
  assign vga.video_on    = h_active & v_active;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;
  assign vga.h_phase     = h_phase;
  assign vga.v_phase     = v_phase;
endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: three timing configurations checked every clk
// against a closed-form model of position versus clocks since reset release.
module tb_vga_controller;
  import vga_pkg::*;

  typedef struct packed {
    int div_n;
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
  } cfg_t;

  typedef struct packed {
    logic               pix_en;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               hs;
    logic               vs;
    logic               von;
    logic               ls;
    logic               fs;
  } obs_t;

  localparam cfg_t C_DEF = '{div_n: 2, ha: 640, hf: 16, hs: 96, hb: 48,
                             va: 480, vf: 10, vs: 2, vb: 33};
  localparam cfg_t C_S2  = '{div_n: 2, ha: 6, hf: 2, hs: 3, hb: 2,
                             va: 4, vf: 1, vs: 2, vb: 2};
  localparam cfg_t C_S1  = '{div_n: 1, ha: 5, hf: 1, hs: 2, hb: 3,
                             va: 3, vf: 2, vs: 1, vb: 1};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vga_if if_def ();
  vga_if if_s2 ();
  vga_if if_s1 ();

  vga_controller #(
    .CLK_DIV (C_DEF.div_n),
    .H_ACTIVE(C_DEF.ha), .H_FP(C_DEF.hf), .H_SYNC(C_DEF.hs), .H_BP(C_DEF.hb),
    .V_ACTIVE(C_DEF.va), .V_FP(C_DEF.vf), .V_SYNC(C_DEF.vs), .V_BP(C_DEF.vb)
  ) u_def (
    .clk (clk),
    .rst (rst),
    .vga (if_def)
  );

  vga_controller #(
    .CLK_DIV (C_S2.div_n),
    .H_ACTIVE(C_S2.ha), .H_FP(C_S2.hf), .H_SYNC(C_S2.hs), .H_BP(C_S2.hb),
    .V_ACTIVE(C_S2.va), .V_FP(C_S2.vf), .V_SYNC(C_S2.vs), .V_BP(C_S2.vb)
  ) u_s2 (
    .clk (clk),
    .rst (rst),
    .vga (if_s2)
  );

  vga_controller #(
    .CLK_DIV (C_S1.div_n),
    .H_ACTIVE(C_S1.ha), .H_FP(C_S1.hf), .H_SYNC(C_S1.hs), .H_BP(C_S1.hb),
    .V_ACTIVE(C_S1.va), .V_FP(C_S1.vf), .V_SYNC(C_S1.vs), .V_BP(C_S1.vb)
  ) u_s1 (
    .clk (clk),
    .rst (rst),
    .vga (if_s1)
  );

  int tests_run = 0;
  int fails     = 0;
  int k         = 0;
  bit in_rst    = 1'b1;
  int hs_low_cnt = 0;
  int ls_cnt     = 0;

  // k = clk edges since reset release; strobes so far = k / div; strobe n
  // shows linear pixel n-1 of the raster, strobe 0 is the last pixel.
  function automatic obs_t model(input int kk, input bit r, input cfg_t c);
    obs_t e;
    int ht, vt, n, lin, x, y;
    bit upd;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    n  = r ? 0 : kk / c.div_n;
    if (n == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      lin = (n - 1) % (ht * vt);
      x   = lin % ht;
      y   = lin / ht;
    end
    upd      = !r && (kk > 0) && (kk % c.div_n == 0);
    e.pix_en = !r && ((kk + 1) % c.div_n == 0);
    e.x      = COORD_W'(x);
    e.y      = COORD_W'(y);
    e.hs     = !((x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs));
    e.vs     = !((y >= c.va + c.vf) && (y < c.va + c.vf + c.vs));
    e.von    = (x < c.ha) && (y < c.va);
    e.ls     = upd && (x == 0);
    e.fs     = upd && (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic cmp(input string tag, input obs_t o, input obs_t e);
    tests_run++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s k=%0d rst=%0b: got pix=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, expected pix=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
             tag, k, in_rst, o.pix_en, o.x, o.y, o.hs, o.vs, o.von, o.ls, o.fs,
             e.pix_en, e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs);
    end
  endtask

  task automatic check_all();
    obs_t o;
    o = {if_def.pix_en, if_def.Q_X, if_def.Q_Y, if_def.hsync, if_def.vsync,
         if_def.video_on, if_def.line_start, if_def.frame_start};
    cmp("def", o, model(k, in_rst, C_DEF));
    o = {if_s2.pix_en, if_s2.Q_X, if_s2.Q_Y, if_s2.hsync, if_s2.vsync,
         if_s2.video_on, if_s2.line_start, if_s2.frame_start};
    cmp("s2", o, model(k, in_rst, C_S2));
    o = {if_s1.pix_en, if_s1.Q_X, if_s1.Q_Y, if_s1.hsync, if_s1.vsync,
         if_s1.video_on, if_s1.line_start, if_s1.frame_start};
    cmp("s1", o, model(k, in_rst, C_S1));
  endtask

  task automatic run(input int n_clk, input bit track);
    for (int i = 0; i < n_clk; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_all();
      if (track) begin
        if (if_def.pix_en && !if_def.hsync && k >= 2 && k <= 1601) hs_low_cnt++;
        if (if_def.line_start) ls_cnt++;
      end
    end
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst    = 1'b1;
    in_rst = 1'b1;
    k      = 0;
    #1;
    check_all();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_all();
    end
    #($urandom_range(1, 3));
    rst    = 1'b0;
    in_rst = 1'b0;
    k      = 0;
    #1;
    check_all();
  endtask

  initial begin
    rst    = 1'b1;
    in_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all();
    end
    #1;
    rst    = 1'b0;
    in_rst = 1'b0;
    k      = 0;
    #1;
    check_all();

    // Slightly over one default line: covers first wrap and second line_start.
    run(1700, 1'b1);

    tests_run++;
    assert (hs_low_cnt === 96) else begin
      fails++;
      $error("FAIL hsync_low_strobes: got %0d, expected 96", hs_low_cnt);
    end
    tests_run++;
    assert (ls_cnt === 2) else begin
      fails++;
      $error("FAIL line_start_count: got %0d, expected 2", ls_cnt);
    end

    for (int seg = 0; seg < 8; seg++) begin
      async_reset(int'($urandom_range(1, 4)));
      run(int'($urandom_range(40, 1200)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/vga_controller.md
# vga_controller

Pixel-timing generator for the VGA display path. Divides the system clock down to the pixel rate and runs horizontal/vertical counters through active, front-porch, sync and back-porch phases. Drives `Q_X`/`Q_Y` straight into the shape/area-enable stages (rectangle and rounded-square detectors) and the sync/blanking signals into the DAC/connector. Default: 640x480@60 from 50 MHz.

## Interface
- `CLK_DIV`, 2: system clocks per pixel (≥1)
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal phases in pixels
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical phases in lines
- Derived: H_TOTAL = 800, V_TOTAL = 525; both must be ≤ 1024.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `pix_en`  out  1  pixel strobe, one clk wide, every CLK_DIV clks
- `Q_X`  out  10  current column, 0..H_TOTAL-1
- `Q_Y`  out  10  current row, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `video_on`  out  1  high when `Q_X`<H_ACTIVE and `Q_Y`<V_ACTIVE
- `line_start`  out  1  one-clk pulse when `Q_X` becomes 0
- `frame_start`  out  1  one-clk pulse when (`Q_X`,`Q_Y`) becomes (0,0)

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div_cnt`==CLK_DIV-1) and not `rst`. With CLK_DIV=1, `pix_en` is constantly 1 outside reset.
- All counter and decode registers update only on clk edges where `pix_en`=1.
- H counter: increments each pixel and wraps H_TOTAL-1→0. On that wrap, the V counter increments, wrapping V_TOTAL-1→0.
- H phase FSM: H_ACT [0,639] → H_FP [640,655] → H_SYNC [656,751] → H_BP [752,799] → H_ACT. V phase FSM has the same four phases over lines: [0,479], [480,489], [490,491], [492,524]. The V FSM advances only on H wrap.
- `hsync`=0 only in H_SYNC; `vsync`=0 only in V_SYNC; `video_on` = H_ACT and V_ACT.
- All outputs except `pix_en` are registered. They are computed from next-counter values, so they are aligned with the `Q_X`/`Q_Y` they accompany. There is no extra pipeline skew.
- Reset values: `Q_X`=H_TOTAL-1 (799), `Q_Y`=V_TOTAL-1 (524), `hsync`=1, `vsync`=1, `video_on`=0, `line_start`=0, `frame_start`=0, `pix_en`=0, `div_cnt`=0, both FSMs in BP. Because of these values, the first pixel strobe wraps cleanly to (0,0) and produces a full first frame.

## Timing
- After reset deasserts, `pix_en` first rises in clk cycle CLK_DIV-1, counting from 0. At that edge `Q`=(0,0), `video_on`=1, `line_start`=`frame_start`=1.
- `line_start` and `frame_start` stay high for exactly one clk: the cycle immediately after the updating edge. This holds even though `Q` is stable for CLK_DIV clks.
- Each `Q` value holds for CLK_DIV clks.
- Line period = 800 pixel strobes. Frame period = 420 000 strobes, which is 840 000 clks at CLK_DIV=2.
- At (799,524)→(0,0), the H and V wraps happen on the same edge. `line_start` and `frame_start` assert together.
- `rst` mid-operation: all outputs take their reset values immediately, with no clk required. Restart follows the post-reset sequence above and carries no state from before the reset.
- Sync polarity is fixed active low; it is not parameterised.

## Structure
- Shared `vga_pkg`:
  - default timing localparams (H_/V_ phase widths, totals);
  - `typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} vga_phase_t`;
  - coordinate width constant `COORD_W`=10.
- One sub-module, `vga_axis_counter`:
  - parameterised by the four phase widths;
  - inputs: advance enable;
  - outputs: count, phase, sync_n, active, wrap.
- `vga_controller` instantiates it twice. H is enabled by `pix_en`; V is enabled by `pix_en` and H wrap. The divider and the start-pulse registers live in the top module.

## Test plan
- Hold `rst`=1 for 5 clks → `Q_X`=799, `Q_Y`=524, `hsync`=`vsync`=1, `video_on`=0, `pix_en`=0 throughout.
- Release `rst` with CLK_DIV=2 → `pix_en` high in cycle 1. In cycle 2: `Q`=(0,0), `video_on`=1, `frame_start`=`line_start`=1 for that single clk. `pix_en` then alternates 0/1.
- Run one line → `video_on` falls when `Q_X`=640. `hsync` is low exactly for `Q_X` 656..751 (96 strobes). `line_start` recurs every 800 strobes.
- Run one full frame → `vsync` is low only for `Q_Y` 490..491. `video_on` stays 0 for `Q_Y`≥480. `frame_start` recurs after exactly 840 000 clks. There is one `frame_start` per frame.
- Observe wrap (799,524)→(0,0) → `Q_Y` resets on the same edge as `Q_X`, and both start pulses fire together.
- Assert `rst` asynchronously between clk edges at `Q`=(300,200) → outputs go to reset values before the next edge. After release, the post-reset sequence repeats exactly. Repeat with CLK_DIV=1 and check that `pix_en` stays continuously high.
